// File: rtl/fetch_stage.sv
// IF stage of the 16-bit pipelined core: owns the PC, fetches from a variable-latency
// instruction memory and drives the IF/ID boundary. Define FETCH_SKID_EN for a 1-entry skid buffer.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_pc,
    input  logic        en_ifid,
    input  logic        flush_ifid,
    input  logic        jump_pred,
    input  logic [15:0] jump_pred_adr,
    input  logic        jump_pred_miss,
    input  logic [15:0] pcinc_evac,
    input  logic        jump_pred_adr_miss,
    input  logic [15:0] fix_adr,
    output logic        imem_req,
    output logic [15:0] imem_adr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] inst_id,
    output logic [15:0] pcinc_id,
    output logic        flushed
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state;
    logic [15:0] pc;
    logic        drop;

    logic        hold_valid;
    logic [15:0] hold_word;
    logic [15:0] hold_pcinc;

`ifdef FETCH_SKID_EN
    localparam logic [1:0] DEPTH = 2'd2;
    logic        skid_valid;
    logic [15:0] skid_word;
    logic [15:0] skid_pcinc;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    logic        miss;
    logic        redirect;
    logic [15:0] target;
    logic [15:0] pc_seq;
    logic        outstanding;
    logic        complete;
    logic        resp;
    logic        take;
    logic        deliver_hold;
    logic        deliver_resp;
    logic        push;
    logic [1:0]  count_now;
    logic [1:0]  count_next;
    logic        space;

    // Buffered words (held word, plus skid entry) always drain ahead of a fresh memory word.
    always_comb begin
        miss     = jump_pred_adr_miss | jump_pred_miss;
        redirect = miss | (jump_pred & en_pc);
        if (jump_pred_adr_miss)
            target = fix_adr;
        else if (jump_pred_miss)
            target = pcinc_evac;
        else
            target = jump_pred_adr;
        pc_seq       = pc + 16'd1;
        outstanding  = (state == S_REQ) || (state == S_WAIT);
        complete     = outstanding & imem_ready;
        resp         = complete & ~drop;
        take         = en_ifid & ~flush_ifid;
        deliver_hold = take & hold_valid;
        deliver_resp = take & ~hold_valid & resp;
        push         = resp & ~deliver_resp;
`ifdef FETCH_SKID_EN
        count_now = {1'b0, hold_valid} + {1'b0, skid_valid};
`else
        count_now = {1'b0, hold_valid};
`endif
        count_next = count_now - {1'b0, deliver_hold} + {1'b0, push};
        space      = count_next < DEPTH;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            imem_req <= 1'b0;
            imem_adr <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
            // An unanswered request must stay on the bus; its answer is thrown away later.
            if (outstanding && !imem_ready) begin
                drop  <= 1'b1;
                state <= S_WAIT;
            end else begin
                drop     <= 1'b0;
                state    <= S_REQ;
                imem_req <= 1'b1;
                imem_adr <= target;
            end
        end else begin
            if (resp)
                pc <= pc_seq;
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                    imem_adr <= pc;
                end
                S_REQ, S_WAIT: begin
                    if (complete) begin
                        drop <= 1'b0;
                        if (space) begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                            imem_adr <= resp ? pc_seq : pc;
                        end else begin
                            state    <= S_HOLD;
                            imem_req <= 1'b0;
                        end
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (space) begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                        imem_adr <= pc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid <= 1'b0;
            hold_word  <= NOP_INST;
            hold_pcinc <= 16'h0000;
`ifdef FETCH_SKID_EN
            skid_valid <= 1'b0;
            skid_word  <= NOP_INST;
            skid_pcinc <= 16'h0000;
`endif
        end else if (redirect) begin
            hold_valid <= 1'b0;
`ifdef FETCH_SKID_EN
            skid_valid <= 1'b0;
`endif
        end else begin
`ifdef FETCH_SKID_EN
            if (deliver_hold) begin
                hold_valid <= skid_valid;
                hold_word  <= skid_word;
                hold_pcinc <= skid_pcinc;
                skid_valid <= 1'b0;
            end
            // After a drain the hold slot is occupied only if the skid entry moved into it.
            if (push) begin
                if (deliver_hold ? skid_valid : hold_valid) begin
                    skid_valid <= 1'b1;
                    skid_word  <= imem_rdata;
                    skid_pcinc <= pc_seq;
                end else begin
                    hold_valid <= 1'b1;
                    hold_word  <= imem_rdata;
                    hold_pcinc <= pc_seq;
                end
            end
`else
            if (deliver_hold)
                hold_valid <= 1'b0;
            if (push) begin
                hold_valid <= 1'b1;
                hold_word  <= imem_rdata;
                hold_pcinc <= pc_seq;
            end
`endif
        end
    end

    // IF/ID register: a bubble is loaded whenever decode takes a slot that has no valid word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_id  <= NOP_INST;
            pcinc_id <= 16'h0000;
            flushed  <= 1'b1;
        end else if (redirect) begin
            if (flush_ifid || miss || en_ifid) begin
                inst_id <= NOP_INST;
                flushed <= 1'b1;
            end
        end else if (flush_ifid) begin
            inst_id <= NOP_INST;
            flushed <= 1'b1;
        end else if (en_ifid) begin
            if (deliver_hold) begin
                inst_id  <= hold_word;
                pcinc_id <= hold_pcinc;
                flushed  <= 1'b0;
            end else if (deliver_resp) begin
                inst_id  <= imem_rdata;
                pcinc_id <= pc_seq;
                flushed  <= 1'b0;
            end else begin
                inst_id <= NOP_INST;
                flushed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory answers with adr ^ 16'h1000 whenever imem_ready is driven high.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        en_pc;
    logic        en_ifid;
    logic        flush_ifid;
    logic        jump_pred;
    logic [15:0] jump_pred_adr;
    logic        jump_pred_miss;
    logic [15:0] pcinc_evac;
    logic        jump_pred_adr_miss;
    logic [15:0] fix_adr;
    logic        imem_req;
    logic [15:0] imem_adr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] inst_id;
    logic [15:0] pcinc_id;
    logic        flushed;

    int compared;
    int mismatched;
    int loads;
    int extra_reqs;

    fetch_stage #(
        .RESET_PC(16'h0000),
        .NOP_INST(16'h0000)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .en_pc              (en_pc),
        .en_ifid            (en_ifid),
        .flush_ifid         (flush_ifid),
        .jump_pred          (jump_pred),
        .jump_pred_adr      (jump_pred_adr),
        .jump_pred_miss     (jump_pred_miss),
        .pcinc_evac         (pcinc_evac),
        .jump_pred_adr_miss (jump_pred_adr_miss),
        .fix_adr            (fix_adr),
        .imem_req           (imem_req),
        .imem_adr           (imem_adr),
        .imem_ready         (imem_ready),
        .imem_rdata         (imem_rdata),
        .inst_id            (inst_id),
        .pcinc_id           (pcinc_id),
        .flushed            (flushed)
    );

    assign imem_rdata = imem_adr ^ 16'h1000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        compared           = 0;
        mismatched         = 0;
        loads              = 0;
        extra_reqs         = 0;
        reset              = 1'b0;
        en_pc              = 1'b1;
        en_ifid            = 1'b1;
        flush_ifid         = 1'b0;
        jump_pred          = 1'b0;
        jump_pred_adr      = 16'h0000;
        jump_pred_miss     = 1'b0;
        pcinc_evac         = 16'h0000;
        jump_pred_adr_miss = 1'b0;
        fix_adr            = 16'h0000;
        imem_ready         = 1'b1;

        $display("[TB] reset state and zero-wait streaming");
        applyStimulus(2);
        checkOutput("rst_req", 16'(imem_req), 16'h0000);
        checkOutput("rst_adr", imem_adr, 16'h0000);
        checkOutput("rst_inst", inst_id, 16'h0000);
        checkOutput("rst_pcinc", pcinc_id, 16'h0000);
        checkOutput("rst_flushed", 16'(flushed), 16'h0001);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("t1_req_c1", 16'(imem_req), 16'h0001);
        checkOutput("t1_adr_c1", imem_adr, 16'h0000);
        checkOutput("t1_flushed_c1", 16'(flushed), 16'h0001);
        applyStimulus(1);
        checkOutput("t1_inst_c2", inst_id, 16'h1000);
        checkOutput("t1_pcinc_c2", pcinc_id, 16'h0001);
        checkOutput("t1_flushed_c2", 16'(flushed), 16'h0000);
        checkOutput("t1_adr_c2", imem_adr, 16'h0001);
        applyStimulus(1);
        checkOutput("t1_inst_c3", inst_id, 16'h1001);
        checkOutput("t1_adr_c3", imem_adr, 16'h0002);

        $display("[TB] delayed response");
        reset      = 1'b0;
        imem_ready = 1'b0;
        applyStimulus(1);
        reset = 1'b1;
        applyStimulus(1);
        loads += (flushed == 1'b0) ? 1 : 0;
        checkOutput("t2_adr_c1", imem_adr, 16'h0000);
        applyStimulus(1);
        loads += (flushed == 1'b0) ? 1 : 0;
        checkOutput("t2_adr_c2", imem_adr, 16'h0000);
        checkOutput("t2_req_c2", 16'(imem_req), 16'h0001);
        applyStimulus(1);
        loads += (flushed == 1'b0) ? 1 : 0;
        checkOutput("t2_adr_c3", imem_adr, 16'h0000);
        imem_ready = 1'b1;
        applyStimulus(1);
        loads += (flushed == 1'b0) ? 1 : 0;
        checkOutput("t2_inst", inst_id, 16'h1000);
        checkOutput("t2_pcinc", pcinc_id, 16'h0001);
        imem_ready = 1'b0;
        applyStimulus(1);
        loads += (flushed == 1'b0) ? 1 : 0;
        checkOutput("t2_loads", 16'(loads), 16'h0001);
        checkOutput("t2_adr_wait", imem_adr, 16'h0001);

        $display("[TB] predicted jump");
        imem_ready = 1'b1;
        applyStimulus(1);
        checkOutput("t3_inst_pre", inst_id, 16'h1001);
        checkOutput("t3_adr_pre", imem_adr, 16'h0002);
        jump_pred     = 1'b1;
        jump_pred_adr = 16'h0040;
        applyStimulus(1);
        jump_pred = 1'b0;
        checkOutput("t3_adr", imem_adr, 16'h0040);
        checkOutput("t3_bubble", 16'(flushed), 16'h0001);
        applyStimulus(1);
        checkOutput("t3_inst", inst_id, 16'h1040);
        checkOutput("t3_pcinc", pcinc_id, 16'h0041);

        $display("[TB] double miss during wait");
        imem_ready = 1'b0;
        applyStimulus(1);
        jump_pred_miss     = 1'b1;
        pcinc_evac         = 16'h0010;
        jump_pred_adr_miss = 1'b1;
        fix_adr            = 16'h0080;
        en_pc              = 1'b0;
        applyStimulus(1);
        jump_pred_miss     = 1'b0;
        jump_pred_adr_miss = 1'b0;
        en_pc              = 1'b1;
        checkOutput("t4_adr_held", imem_adr, 16'h0041);
        checkOutput("t4_bubble", 16'(flushed), 16'h0001);
        imem_ready = 1'b1;
        applyStimulus(1);
        checkOutput("t4_adr_fix", imem_adr, 16'h0080);
        checkOutput("t4_stale_dropped", 16'(flushed), 16'h0001);
        applyStimulus(1);
        checkOutput("t4_inst", inst_id, 16'h1080);
        checkOutput("t4_pcinc", pcinc_id, 16'h0081);

        $display("[TB] IF/ID stall");
        en_ifid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            extra_reqs += (imem_req == 1'b1) ? 1 : 0;
            checkOutput("t5_inst_held", inst_id, 16'h1080);
        end
`ifdef FETCH_SKID_EN
        checkOutput("t5_reqs", 16'(extra_reqs), 16'h0001);
`else
        checkOutput("t5_reqs", 16'(extra_reqs), 16'h0000);
`endif
        en_ifid = 1'b1;
        applyStimulus(1);
        checkOutput("t5_inst_rel", inst_id, 16'h1081);
        checkOutput("t5_pcinc_rel", pcinc_id, 16'h0082);
        applyStimulus(1);
        checkOutput("t5_inst_next", inst_id, 16'h1082);
        checkOutput("t5_pcinc_next", pcinc_id, 16'h0083);

        $display("[TB] PC wrap");
        jump_pred     = 1'b1;
        jump_pred_adr = 16'hFFFF;
        applyStimulus(1);
        jump_pred = 1'b0;
        checkOutput("t6_adr_ffff", imem_adr, 16'hFFFF);
        applyStimulus(1);
        checkOutput("t6_inst", inst_id, 16'hEFFF);
        checkOutput("t6_pcinc", pcinc_id, 16'h0000);
        checkOutput("t6_adr_wrap", imem_adr, 16'h0000);
        applyStimulus(1);
        checkOutput("t6_inst_wrap", inst_id, 16'h1000);

        $display("[TB] reset during wait");
        imem_ready = 1'b0;
        applyStimulus(2);
        checkOutput("t7_adr_wait", imem_adr, 16'h0001);
        reset = 1'b0;
        #1;
        checkOutput("t7_req_rst", 16'(imem_req), 16'h0000);
        checkOutput("t7_adr_rst", imem_adr, 16'h0000);
        checkOutput("t7_flushed_rst", 16'(flushed), 16'h0001);
        checkOutput("t7_pcinc_rst", pcinc_id, 16'h0000);
        imem_ready = 1'b1;
        applyStimulus(1);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("t7_ignored_inst", inst_id, 16'h0000);
        checkOutput("t7_ignored_flushed", 16'(flushed), 16'h0001);
        checkOutput("t7_refetch_adr", imem_adr, 16'h0000);
        applyStimulus(1);
        checkOutput("t7_inst", inst_id, 16'h1000);
        checkOutput("t7_pcinc", pcinc_id, 16'h0001);

        $display("[TB] flush bubble");
        flush_ifid = 1'b1;
        applyStimulus(1);
        flush_ifid = 1'b0;
        checkOutput("t8_inst_nop", inst_id, 16'h0000);
        checkOutput("t8_flushed", 16'(flushed), 16'h0001);
        checkOutput("t8_pcinc_kept", pcinc_id, 16'h0001);
        applyStimulus(1);
        checkOutput("t8_inst_after", inst_id, 16'h1001);
        checkOutput("t8_pcinc_after", pcinc_id, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
